branch_resolve_unit: RTL and testbench

- EX-stage consumer of the ALU condition flags (zero, sign, overflow, carry) produced by the compare subtraction A-B (ALU sel 4'b0110).
- Evaluates RV32I conditional branches, resolves the target, and flags mispredictions. Flush/redirect is registered one cycle after EX.
- Owns a direct-mapped table of 2-bit saturating counters. IF reads it combinationally; the table is trained at resolve time.
- Also keeps saturating branch and mispredict statistics counters.

---
 rtl/branch_resolve_unit.sv | 120 ++++++++++++
 tb/tb_branch_resolve_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// EX-stage conditional branch resolver with a 2-bit saturating predictor table
// and saturating branch/mispredict statistics.
module branch_resolve_unit #(
    parameter int unsigned IDX_BITS = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ex_valid,
    input  logic             i_ex_is_branch,
    input  logic [2:0]       i_ex_funct3,
    input  logic             i_zero_flag,
    input  logic             i_sign_flag,
    input  logic             i_overflow_flag,
    input  logic             i_carry_flag,
    input  logic [31:0]      i_ex_pc,
    input  logic [31:0]      i_ex_imm,
    input  logic             i_ex_pred_taken,
    input  logic             i_stall,
    input  logic [31:0]      i_if_pc,
    output logic             o_if_pred_taken,
    output logic             o_redirect_valid,
    output logic [31:0]      o_redirect_pc,
    output logic             o_illegal_branch,
    output logic [CNT_W-1:0] o_branch_cnt,
    output logic [CNT_W-1:0] o_mispredict_cnt
);

    localparam int unsigned ENTRIES = 2 ** IDX_BITS;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [1:0]          r_bht [ENTRIES];
    logic                r_redirect_valid;
    logic [31:0]         r_redirect_pc;
    logic                r_illegal_branch;
    logic [CNT_W-1:0]    r_branch_cnt;
    logic [CNT_W-1:0]    r_mispredict_cnt;

    logic [IDX_BITS-1:0] w_if_idx;
    logic [IDX_BITS-1:0] w_ex_idx;
    logic                w_legal;
    logic                w_taken;
    logic                w_resolve;
    logic                w_legal_resolve;
    logic                w_illegal_resolve;
    logic                w_mispredict;
    logic [31:0]         w_target;
    logic [1:0]          w_ctr_old;
    logic [1:0]          w_ctr_new;

    assign w_if_idx = i_if_pc[IDX_BITS+1:2];
    assign w_ex_idx = i_ex_pc[IDX_BITS+1:2];

    // Table read is asynchronous, so a same-cycle update is seen only after the edge.
    assign o_if_pred_taken = r_bht[w_if_idx][1];

    always_comb begin
        w_legal = 1'b1;
        w_taken = 1'b0;
        case (i_ex_funct3)
            3'b000:  w_taken = i_zero_flag;
            3'b001:  w_taken = ~i_zero_flag;
            3'b100:  w_taken = i_sign_flag ^ i_overflow_flag;
            3'b101:  w_taken = ~(i_sign_flag ^ i_overflow_flag);
            3'b110:  w_taken = ~i_carry_flag;
            3'b111:  w_taken = i_carry_flag;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_resolve         = i_ex_valid & i_ex_is_branch & ~i_stall;
    assign w_legal_resolve   = w_resolve & w_legal;
    assign w_illegal_resolve = w_resolve & ~w_legal;
    assign w_mispredict      = w_taken != i_ex_pred_taken;
    assign w_target          = i_ex_pc + (w_taken ? i_ex_imm : 32'd4);

    assign w_ctr_old = r_bht[w_ex_idx];

    always_comb begin
        w_ctr_new = w_ctr_old;
        if (w_taken) begin
            if (w_ctr_old != 2'b11) w_ctr_new = w_ctr_old + 2'd1;
        end else begin
            if (w_ctr_old != 2'b00) w_ctr_new = w_ctr_old - 2'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_bht[i] <= 2'b01;
            end
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'd0;
            r_illegal_branch <= 1'b0;
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            r_redirect_valid <= w_legal_resolve & w_mispredict;
            r_illegal_branch <= w_illegal_resolve;
            if (w_legal_resolve) begin
                r_redirect_pc     <= w_target;
                r_bht[w_ex_idx]   <= w_ctr_new;
                if (r_branch_cnt != '1) begin
                    r_branch_cnt <= r_branch_cnt + CNT_ONE;
                end
                if (w_mispredict && (r_mispredict_cnt != '1)) begin
                    r_mispredict_cnt <= r_mispredict_cnt + CNT_ONE;
                end
            end
        end
    end

    assign o_redirect_valid = r_redirect_valid;
    assign o_redirect_pc    = r_redirect_pc;
    assign o_illegal_branch = r_illegal_branch;
    assign o_branch_cnt     = r_branch_cnt;
    assign o_mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed plus randomized bench for branch_resolve_unit; expectations come from
// an operand-level model (branches decided by comparing A and B directly).
module tb_branch_resolve_unit;

    localparam int unsigned TB_IDX  = 4;
    localparam int unsigned TB_CNTW = 4;
    localparam int          CNT_MAX = (1 << TB_CNTW) - 1;

    logic               clk;
    logic               rst_n;
    logic               ex_valid;
    logic               ex_is_branch;
    logic [2:0]         ex_funct3;
    logic               zero_flag;
    logic               sign_flag;
    logic               overflow_flag;
    logic               carry_flag;
    logic [31:0]        ex_pc;
    logic [31:0]        ex_imm;
    logic               ex_pred_taken;
    logic               stall;
    logic [31:0]        if_pc;
    logic               if_pred_taken;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               illegal_branch;
    logic [TB_CNTW-1:0] branch_cnt;
    logic [TB_CNTW-1:0] mispredict_cnt;

    branch_resolve_unit #(
        .IDX_BITS(TB_IDX),
        .CNT_W   (TB_CNTW)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_ex_valid      (ex_valid),
        .i_ex_is_branch  (ex_is_branch),
        .i_ex_funct3     (ex_funct3),
        .i_zero_flag     (zero_flag),
        .i_sign_flag     (sign_flag),
        .i_overflow_flag (overflow_flag),
        .i_carry_flag    (carry_flag),
        .i_ex_pc         (ex_pc),
        .i_ex_imm        (ex_imm),
        .i_ex_pred_taken (ex_pred_taken),
        .i_stall         (stall),
        .i_if_pc         (if_pc),
        .o_if_pred_taken (if_pred_taken),
        .o_redirect_valid(redirect_valid),
        .o_redirect_pc   (redirect_pc),
        .o_illegal_branch(illegal_branch),
        .o_branch_cnt    (branch_cnt),
        .o_mispredict_cnt(mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state
    int          m_tbl [16];
    bit          m_rv;
    bit          m_ill;
    logic [31:0] m_rpc;
    int          m_bc;
    int          m_mc;
    logic [31:0] op_a;
    logic [31:0] op_b;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // The ALU flags an A-B compare would produce.
    task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] diff;
        op_a          = a;
        op_b          = b;
        diff          = a - b;
        zero_flag     = (diff == 32'd0);
        sign_flag     = diff[31];
        overflow_flag = (a[31] != b[31]) && (diff[31] != a[31]);
        carry_flag    = (a >= b);
    endtask

    task automatic set_branch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] pc, input logic [31:0] imm, input logic pred);
        ex_valid      = 1'b1;
        ex_is_branch  = 1'b1;
        ex_funct3     = f3;
        ex_pc         = pc;
        ex_imm        = imm;
        ex_pred_taken = pred;
        stall         = 1'b0;
        set_ops(a, b);
    endtask

    task automatic set_idle();
        ex_valid     = 1'b0;
        ex_is_branch = 1'b0;
        stall        = 1'b0;
        set_ops($urandom, $urandom);
    endtask

    function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_edge();
        bit tk;
        bit mis;
        int idx;
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_tbl[i] = 1;
            m_rv = 0; m_ill = 0; m_rpc = 32'd0; m_bc = 0; m_mc = 0;
        end else if (ex_valid && ex_is_branch && !stall) begin
            if (ex_funct3 == 3'd2 || ex_funct3 == 3'd3) begin
                m_ill = 1;
                m_rv  = 0;
            end else begin
                tk    = ref_taken(ex_funct3, op_a, op_b);
                mis   = (tk != ex_pred_taken);
                idx   = int'(ex_pc[5:2]);
                m_ill = 0;
                m_rv  = mis;
                m_rpc = tk ? ex_pc + ex_imm : ex_pc + 32'd4;
                if (m_bc < CNT_MAX) m_bc++;
                if (mis && m_mc < CNT_MAX) m_mc++;
                if (tk) m_tbl[idx] = (m_tbl[idx] < 3) ? m_tbl[idx] + 1 : 3;
                else    m_tbl[idx] = (m_tbl[idx] > 0) ? m_tbl[idx] - 1 : 0;
            end
        end else begin
            m_rv  = 0;
            m_ill = 0;
        end
    endtask

    task automatic check_pred(input string tag);
        check(tag, {31'd0, if_pred_taken}, {31'd0, m_tbl[int'(if_pc[5:2])] >= 2});
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ".redirect_valid"}, {31'd0, redirect_valid}, {31'd0, m_rv});
        check({tag, ".redirect_pc"}, redirect_pc, m_rpc);
        check({tag, ".illegal"}, {31'd0, illegal_branch}, {31'd0, m_ill});
        check({tag, ".branch_cnt"}, {28'd0, branch_cnt}, 32'(m_bc));
        check({tag, ".mispredict_cnt"}, {28'd0, mispredict_cnt}, 32'(m_mc));
        check_pred({tag, ".if_pred"});
    endtask

    initial begin
        rst_n = 1'b0;
        if_pc = 32'd0;
        ex_funct3 = 3'd0;
        ex_pc = 32'd0;
        ex_imm = 32'd0;
        ex_pred_taken = 1'b0;
        set_idle();
        tick("reset0");
        tick("reset1");
        rst_n = 1'b1;

        // Mispredicted BEQ, then the pulse must drop
        set_branch(3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
        tick("beq_mis");
        check("beq_rpc_abs", redirect_pc, 32'h120);
        set_idle();
        tick("beq_after");

        // Correctly predicted not-taken BLTU
        set_branch(3'd6, 32'd9, 32'd3, 32'h200, 32'h40, 1'b0);
        tick("bltu_ok");
        check("bltu_rpc_abs", redirect_pc, 32'h204);

        // Signed compare with overflow, backward target
        set_branch(3'd4, 32'h8000_0000, 32'd1, 32'h300, 32'hFFFF_FFF0, 1'b0);
        tick("blt_ovf");
        check("blt_rpc_abs", redirect_pc, 32'h2F0);
        set_branch(3'd5, 32'h8000_0000, 32'd1, 32'h300, 32'hFFFF_FFF0, 1'b1);
        tick("bge_ovf");
        check("bge_rpc_abs", redirect_pc, 32'h304);

        // Training, collision lookup, saturation and aliasing at index 0
        if_pc = 32'h40;
        for (int k = 0; k < 5; k++) begin
            set_branch(3'd1, 32'd1, 32'd2, 32'h40, 32'h8, 1'b1);
            #1;
            check_pred("train_pre");
            tick("train");
        end
        check("train_sat", {31'd0, if_pred_taken}, 32'd1);
        if_pc = 32'h80;
        #1;
        check_pred("alias");

        // Reserved funct3 and stalled resolve
        set_branch(3'd2, 32'd1, 32'd1, 32'h44, 32'h10, 1'b0);
        tick("reserved");
        set_branch(3'd3, 32'd1, 32'd1, 32'h44, 32'h10, 1'b1);
        tick("reserved3");
        set_branch(3'd0, 32'd7, 32'd7, 32'h48, 32'h10, 1'b0);
        stall = 1'b1;
        tick("stalled");
        set_idle();
        tick("idle");

        // Reset on the same edge as a mispredicting resolve
        set_branch(3'd0, 32'd3, 32'd3, 32'h40, 32'h100, 1'b0);
        rst_n = 1'b0;
        tick("rst_mid");
        rst_n = 1'b1;
        set_idle();
        for (int i = 0; i < 16; i++) begin
            if_pc = 32'(i * 4);
            #1;
            check_pred("rst_sweep");
        end
        set_branch(3'd7, 32'd10, 32'd4, 32'h40, 32'h80, 1'b0);
        tick("post_rst");

        // Randomized traffic, with frequent index collisions
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) b = {a[31], b[30:0]};
            set_branch(3'($urandom_range(0, 7)), a, b, $urandom & 32'hFFFF_FFFC,
                       32'($signed({$urandom_range(0, 8191), 1'b0}) - 8192),
                       1'($urandom_range(0, 1)));
            ex_valid     = ($urandom_range(0, 3) != 0);
            ex_is_branch = ($urandom_range(0, 5) != 0);
            stall        = ($urandom_range(0, 4) == 0);
            rst_n        = ($urandom_range(0, 59) != 0);
            if_pc        = ($urandom_range(0, 1) == 0) ? ex_pc : ($urandom & 32'hFFFF_FFFC);
            #1;
            check_pred("rand_pre");
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
